// File: rtl/uart_rx_oversampler.sv
// 16x oversampling UART receiver: 2-flop synchroniser, mid-bit majority vote,
// false-start rejection and framing-error detection. Bytes go straight to a FIFO.
module uart_rx_oversampler #(
  parameter int baudrate   = 9600,
  parameter int clk_frec   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       rx,
  output logic [7:0] byte_rx,
  output logic       new_byte_rx,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = clk_frec / (baudrate * OVERSAMPLE);
  localparam int TW  = $clog2(DIV) + 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  generate
    if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx_oversampler: OVERSAMPLE must be 16");
    end
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_oversampler: clk_frec too low for baudrate*16");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      b_q, b_d;
  logic            smp7_q, smp7_d;
  logic            smp8_q, smp8_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            new_q, new_d;
  logic            ferr_q, ferr_d;
  logic            tick;
  logic            maj;
  logic            running;

  assign tick    = (tick_q == TICK_MAX);
  // Third vote is the live s=9 sample, so the decision lands on that tick.
  assign maj     = majority3(smp7_q, smp8_q, rx_s_q);
  assign running = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    s_d     = s_q;
    b_d     = b_q;
    smp7_d  = smp7_q;
    smp8_d  = smp8_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    new_d   = 1'b0;
    ferr_d  = 1'b0;

    if (running) begin
      tick_d = tick ? '0 : tick_q + TW'(1);
      if (tick) begin
        s_d = s_q + 4'd1;
        if (s_q == 4'd7) smp7_d = rx_s_q;
        if (s_q == 4'd8) smp8_d = rx_s_q;
      end
    end

    case (state_q)
      IDLE: begin
        // Counters are cleared here so a start edge seen on the return
        // cycle begins the next frame with fresh indexing.
        tick_d = '0;
        s_d    = '0;
        b_d    = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick && s_q == 4'd9 && maj) begin
          state_d = IDLE;
        end else if (tick && s_q == 4'd15) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick && s_q == 4'd9) shift_d = {maj, shift_q[7:1]};
        if (tick && s_q == 4'd15) begin
          b_d = b_q + 3'd1;
          if (b_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && s_q == 4'd9) begin
          if (maj) begin
            byte_d  = shift_q;
            new_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        tick_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tick_q    <= '0;
      s_q       <= '0;
      b_q       <= '0;
      byte_q    <= 8'h00;
      new_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      tick_q    <= tick_d;
      s_q       <= s_d;
      b_q       <= b_d;
      byte_q    <= byte_d;
      new_q     <= new_d;
      ferr_q    <= ferr_d;
    end
  end

  // Vote samples and shift register are pure data, always rewritten before use.
  always_ff @(posedge clk) begin
    smp7_q  <= smp7_d;
    smp8_q  <= smp8_d;
    shift_q <= shift_d;
  end

  assign byte_rx     = byte_q;
  assign new_byte_rx = new_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Oversampling UART receiver that deserialises the asynchronous `rx` line into bytes for the RX FIFO of the AXI UART peripheral. It sits directly upstream of the FIFO write port: `byte_rx` feeds the FIFO write data and `new_byte_rx` feeds the FIFO write strobe. Noise immunity comes from a 2-flop synchroniser, 16x oversampling, mid-bit majority voting and false-start rejection. Framing errors are flagged and never written.

## Interface
- `baudrate`, 9600: line bit rate in bit/s.
- `clk_frec`, 50000000: `clk` frequency in Hz.
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; any other value is an elaboration error.
- `clk` input 1: single clock; all logic on rising edge.
- `arstn` input 1: reset, asynchronous, active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `byte_rx` output 8: last correctly received byte.
- `new_byte_rx` output 1: one-cycle pulse when `byte_rx` has been updated.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- **Tick divisor.**
  - `DIV = clk_frec / (baudrate*16)`, integer floor.
  - `DIV < 1` is an elaboration error.
  - The tick counter is `$clog2(DIV)+1` bits wide, counts 0..DIV-1, and emits a one-cycle tick at DIV-1.
- **Synchroniser.** `rx` passes through two flops to give `rx_s`. Only `rx_s` is used internally.
- **Sample indexing.**
  - The sample counter `s` (4 bits) and the bit counter `b` (3 bits) are cleared, and the tick counter reset to 0, on entry to START.
  - `s` increments on each tick and wraps 15→0.
  - Samples at `s` = 7, 8, 9 are stored. The majority of the three is the bit value, evaluated on the `s`=9 tick.
- **States:**
  - IDLE: `rx_s`==0 → START.
  - START: on the `s`=9 tick, majority 1 → IDLE (false start, no output); majority 0 → continue. On the `s`=15 tick → DATA.
  - DATA: on each `s`=9 tick, shift the majority into the shift register MSB (shift right, so LSB is received first). On each `s`=15 tick, `b` increments; if `b` was 7 → STOP.
  - STOP: on the `s`=9 tick:
    - majority 1: `byte_rx` ← shift register, pulse `new_byte_rx`, → IDLE.
    - majority 0: pulse `frame_err`, `byte_rx` unchanged, → WAIT_IDLE.
  - WAIT_IDLE: stay while `rx_s`==0 (break or line fault); → IDLE when `rx_s`==1.
- Returning to IDLE at mid-stop allows back-to-back frames with zero idle time, tolerating about ±4 % baud mismatch.
- `new_byte_rx` and `frame_err` are never high in the same cycle.
- No flow control. The downstream FIFO drops on full; this block neither knows nor cares.

## Timing
- Reset values:
  - `byte_rx` = 0x00
  - `new_byte_rx` = 0
  - `frame_err` = 0
  - `busy` = 0
  - state IDLE, all counters 0, synchroniser flops 1
- Reset assertion mid-frame aborts immediately to these values. No pulse is produced for the partial frame.
- Entry to START is 3 clock edges after `rx` falls: 2 synchroniser edges plus 1 state edge.
- Latency:
  - The stop-bit `s`=9 tick is tick #153 from START entry, at clock 154·DIV after entry.
  - `new_byte_rx` therefore rises 154·DIV+3 edges after the `rx` falling edge. Benches allow ±1 for asynchronous stimulus phase.
  - `byte_rx` is valid in the same cycle as `new_byte_rx` and holds until the next good frame.
- `busy` rises 3 edges after `rx` falls. It falls on the same edge that `new_byte_rx` rises, or when leaving WAIT_IDLE.
- A falling edge seen in the cycle the block returns to IDLE starts a new frame on the next edge. No idle gap is required.

## Test plan
All scenarios use `clk_frec`=1600000 and `baudrate`=10000, giving DIV=10 and 160 clocks per bit.
- Reset values: hold `arstn`=0 with `rx` toggling → all outputs at reset values. Release → `busy`=0 while `rx`=1.
- Single frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → `new_byte_rx` is one pulse at 1543±1 clocks after the start edge, `byte_rx`=0xA5, `frame_err` never high.
- Glitch rejection:
  - `rx` low for 40 clocks → no `new_byte_rx`, no `frame_err`, `busy` back to 0 by clock 103.
  - Separately, invert `rx` for 10 clocks centred on sample 8 of data bit 3 of 0x3C → `byte_rx`=0x3C.
- Framing error: send 0x55 with stop bit 0, then hold `rx` low for 500 clocks → one `frame_err` pulse, no `new_byte_rx`, `byte_rx` keeps its prior value, `busy` stays high until `rx` returns high. A following 0x81 frame is received correctly.
- Back-to-back: frames 0x00, 0xFF, 0x7E with zero idle bits → exactly three `new_byte_rx` pulses with `byte_rx` values 0x00, 0xFF, 0x7E in order.
- Reset mid-frame: assert `arstn` during data bit 4 of 0x99, release, then send 0x42 → no output for 0x99; `byte_rx`=0x42 with one pulse.
